// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, FSM state and ALU-op encodings for cpu_mc
package cpu_pkg;

   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;
   localparam logic [7:0] OP_J     = 8'h06;
   localparam logic [7:0] OP_BEQ   = 8'h07;
   localparam logic [7:0] OP_LWD   = 8'h08;
   localparam logic [7:0] OP_LWI   = 8'h09;
   localparam logic [7:0] OP_SWD   = 8'h0A;
   localparam logic [7:0] OP_SWI   = 8'h0B;
   localparam logic [7:0] OP_BNE   = 8'h0C;
   localparam logic [7:0] OP_SLL   = 8'h0D;
   localparam logic [7:0] OP_SRL   = 8'h0E;
   localparam logic [7:0] OP_SRA   = 8'h0F;
   localparam logic [7:0] OP_ROR   = 8'h10;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_MEM   = 2'd2;
   localparam logic [1:0] ST_WB    = 2'd3;

   typedef enum logic [3:0] {
      ALU_PASS,
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA,
      ALU_ROR
   } alu_op_t;

   // Loads, stores, branches and undefined opcodes pass operand B through;
   // for memory ops that operand is the effective address.
   function automatic alu_op_t alu_op_of(input logic [7:0] op);
      case (op)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         OP_SLL:  return ALU_SLL;
         OP_SRL:  return ALU_SRL;
         OP_SRA:  return ALU_SRA;
         OP_ROR:  return ALU_ROR;
         default: return ALU_PASS;
      endcase
   endfunction

endpackage

// File: rtl/reg_file_p.sv
// rtl/reg_file_p.sv - general register file, two async read ports, one sync write port
module reg_file_p #(
   parameter int DATA_W    = 8,
   parameter int REG_COUNT = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [$clog2(REG_COUNT)-1:0] wr_addr,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic [$clog2(REG_COUNT)-1:0] rd_addr1,
   output logic [DATA_W-1:0]            rd_data1,
   input  logic [$clog2(REG_COUNT)-1:0] rd_addr2,
   output logic [DATA_W-1:0]            rd_data2
);

   logic [DATA_W-1:0] regs [REG_COUNT];

   // Clear every register on reset, otherwise write one register per edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end

   assign rd_data1 = regs[rd_addr1];
   assign rd_data2 = regs[rd_addr2];

endmodule

// File: rtl/cpu_mc.sv
// rtl/cpu_mc.sv - multi-cycle CPU: FETCH/EXEC/MEM/WB FSM, ALU and branch unit
module cpu_mc
   import cpu_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int REG_COUNT = 8,
   parameter int PC_W      = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   output logic [PC_W-1:0]   PC,
   input  logic [31:0]       INSTRUCTION,
   input  logic              BUSYWAIT_INS,
   output logic              READ_MEM,
   output logic              WRITE_MEM,
   output logic [DATA_W-1:0] ADDRESS,
   output logic [DATA_W-1:0] WRITEDATA,
   input  logic [DATA_W-1:0] READDATA,
   input  logic              BUSYWAIT,
   output logic              ILLEGAL
);

   localparam int AW = $clog2(REG_COUNT);
   localparam int SW = $clog2(DATA_W);

   logic [1:0]        state;
   logic [31:0]       ir;
   logic [7:0]        opcode;
   logic [7:0]        amt;
   logic [DATA_W-1:0] rs1, rs2, imm_ext, op_b, alu_y;
   logic [DATA_W-1:0] alu_res, st_data, mem_data;
   logic              is_load, is_store, is_branch, legal, writes_reg;
   logic              br_cond, take_br;
   logic [PC_W-1:0]   pc_inc, br_off;
   logic              unused_src1_hi;

   assign opcode         = ir[31:24];
   assign amt            = ir[7:0];
   assign imm_ext        = DATA_W'($signed(ir[7:0]));
   assign pc_inc         = PC + PC_W'(4);
   assign br_off         = PC_W'($signed(ir[23:16]));
   assign unused_src1_hi = ^ir[15:8];

   reg_file_p #(
      .DATA_W    (DATA_W),
      .REG_COUNT (REG_COUNT)
   ) u_regs (
      .clk      (CLK),
      .rst_n    (RESET),
      .wr_en    ((state == ST_WB) && writes_reg),
      .wr_addr  (ir[16 +: AW]),
      .wr_data  (is_load ? mem_data : alu_res),
      .rd_addr1 (ir[8 +: AW]),
      .rd_data1 (rs1),
      .rd_addr2 (ir[0 +: AW]),
      .rd_data2 (rs2)
   );

   // Instruction class decode; immediate forms take operand B from the imm field
   always_comb begin
      is_load    = (opcode == OP_LWD) || (opcode == OP_LWI);
      is_store   = (opcode == OP_SWD) || (opcode == OP_SWI);
      is_branch  = (opcode == OP_J) || (opcode == OP_BEQ) || (opcode == OP_BNE);
      legal      = (opcode <= OP_ROR);
      writes_reg = legal && !is_store && !is_branch;
      op_b       = ((opcode == OP_LOADI) || (opcode == OP_LWI) || (opcode == OP_SWI)) ? imm_ext : rs2;
      br_cond    = (opcode == OP_J) ||
                   ((opcode == OP_BEQ) && (rs1 == rs2)) ||
                   ((opcode == OP_BNE) && (rs1 != rs2));
   end

   // ALU; shift amounts are the raw unsigned imm byte, rotate uses it mod DATA_W
   always_comb begin
      alu_y = op_b;
      case (alu_op_of(opcode))
         ALU_ADD:  alu_y = rs1 + op_b;
         ALU_SUB:  alu_y = rs1 - op_b;
         ALU_AND:  alu_y = rs1 & op_b;
         ALU_OR:   alu_y = rs1 | op_b;
         ALU_SLL:  alu_y = (32'(amt) >= DATA_W) ? '0 : (rs1 << amt);
         ALU_SRL:  alu_y = (32'(amt) >= DATA_W) ? '0 : (rs1 >> amt);
         ALU_SRA:  alu_y = $signed(rs1) >>> amt;
         ALU_ROR:  alu_y = DATA_W'({rs1, rs1} >> amt[SW-1:0]);
         default:  alu_y = op_b;
      endcase
   end

   // Main sequencer: one state per phase, memory phase held while BUSYWAIT is high
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state    <= ST_FETCH;
         ir       <= '0;
         alu_res  <= '0;
         st_data  <= '0;
         mem_data <= '0;
         take_br  <= 1'b0;
         PC       <= '0;
         ILLEGAL  <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (!BUSYWAIT_INS) begin
                  ir    <= INSTRUCTION;
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               alu_res <= alu_y;
               st_data <= rs1;
               take_br <= br_cond;
               if (!legal) ILLEGAL <= 1'b1;
               state   <= (is_load || is_store) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
               if (!BUSYWAIT) begin
                  mem_data <= READDATA;
                  state    <= ST_WB;
               end
            end
            default: begin
               PC    <= take_br ? (pc_inc + (br_off << 2)) : pc_inc;
               state <= ST_FETCH;
            end
         endcase
      end
   end

   assign READ_MEM  = (state == ST_MEM) && is_load;
   assign WRITE_MEM = (state == ST_MEM) && is_store;
   assign ADDRESS   = alu_res;
   assign WRITEDATA = st_data;

endmodule

// File: tb/tb_cpu_mc.sv
// tb/tb_cpu_mc.sv - directed and randomized checks of cpu_mc against a behavioural model
`timescale 1ns/1ps
module tb_cpu_mc;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] ins;
   logic        bw_ins, busywait, sel16;
   logic [15:0] rdata;
   logic [31:0] pc8, pc16;
   logic        rd8, wr8, rd16, wr16, ill8, ill16;
   logic [7:0]  addr8, wd8;
   logic [15:0] addr16, wd16;
   logic [31:0] pc_o, addr_o, wd_o;
   logic        rd_o, wr_o, ill_o;

   int checks   = 0;
   int failures = 0;

   longint      m_reg [8];
   logic [31:0] m_pc;
   logic        m_ill;
   int          W;

   always #5 CLK = ~CLK;

   cpu_mc #(.DATA_W(8), .REG_COUNT(8), .PC_W(32)) u8 (
      .CLK(CLK), .RESET(RESET), .PC(pc8), .INSTRUCTION(ins), .BUSYWAIT_INS(bw_ins | sel16),
      .READ_MEM(rd8), .WRITE_MEM(wr8), .ADDRESS(addr8), .WRITEDATA(wd8),
      .READDATA(rdata[7:0]), .BUSYWAIT(busywait), .ILLEGAL(ill8));

   cpu_mc #(.DATA_W(16), .REG_COUNT(8), .PC_W(32)) u16 (
      .CLK(CLK), .RESET(RESET), .PC(pc16), .INSTRUCTION(ins), .BUSYWAIT_INS(bw_ins | ~sel16),
      .READ_MEM(rd16), .WRITE_MEM(wr16), .ADDRESS(addr16), .WRITEDATA(wd16),
      .READDATA(rdata), .BUSYWAIT(busywait), .ILLEGAL(ill16));

   always_comb begin
      pc_o   = sel16 ? pc16 : pc8;
      rd_o   = sel16 ? rd16 : rd8;
      wr_o   = sel16 ? wr16 : wr8;
      ill_o  = sel16 ? ill16 : ill8;
      addr_o = sel16 ? {16'd0, addr16} : {24'd0, addr8};
      wd_o   = sel16 ? {16'd0, wd16} : {24'd0, wd8};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] d,
                                       input logic [7:0] s1, input logic [7:0] s2);
      return {op, d, s1, s2};
   endfunction

   function automatic longint msk();
      return (longint'(1) << W) - 1;
   endfunction

   function automatic longint sx(input logic [7:0] v);
      longint t;
      t = longint'(v);
      if (t >= 128) t = t - 256;
      return t & msk();
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = 0;
      m_pc  = 32'd0;
      m_ill = 1'b0;
   endfunction

   // Architectural effect of one instruction, written from the instruction-set rules
   function automatic void model_step(input logic [31:0] instr, input logic [31:0] rdv);
      int op, d, s1, s2, amt, off;
      longint a, b, im, r, sa;
      bit wr;
      op  = int'(instr[31:24]);
      d   = int'(instr[23:16]) % 8;
      s1  = int'(instr[15:8]) % 8;
      s2  = int'(instr[7:0]) % 8;
      amt = int'(instr[7:0]);
      off = int'(instr[23:16]);
      if (off >= 128) off = off - 256;
      a  = m_reg[s1];
      b  = m_reg[s2];
      im = sx(instr[7:0]);
      wr = 1;
      r  = 0;
      m_pc = m_pc + 32'd4;
      case (op)
         0:  r = im;
         1:  r = b;
         2:  r = (a + b) & msk();
         3:  r = (a - b) & msk();
         4:  r = a & b;
         5:  r = a | b;
         6:  begin wr = 0; m_pc = m_pc + 32'(off * 4); end
         7:  begin wr = 0; if (a == b) m_pc = m_pc + 32'(off * 4); end
         12: begin wr = 0; if (a != b) m_pc = m_pc + 32'(off * 4); end
         8, 9:   r = longint'(rdv) & msk();
         10, 11: wr = 0;
         13: r = (amt >= W) ? 0 : ((a << amt) & msk());
         14: r = (amt >= W) ? 0 : (a >> amt);
         15: begin
            sa = (a >= (longint'(1) << (W - 1))) ? a - (msk() + 1) : a;
            r  = (sa >>> ((amt >= W) ? W : amt)) & msk();
         end
         16: begin
            r = a;
            for (int k = 0; k < amt % W; k++) r = (r >> 1) | ((r & 1) << (W - 1));
         end
         default: begin wr = 0; m_ill = 1'b1; end
      endcase
      if (wr) m_reg[d] = r;
   endfunction

   // Runs one instruction from FETCH back to FETCH, checking timing and bus behaviour
   task automatic exec(input logic [31:0] instr, input int ins_stall, input int mem_stall,
                       input logic [31:0] rdv);
      int op, s1, s2;
      bit is_ld, is_st;
      longint exp_addr;
      op    = int'(instr[31:24]);
      s1    = int'(instr[15:8]) % 8;
      s2    = int'(instr[7:0]) % 8;
      is_ld = (op == 8) || (op == 9);
      is_st = (op == 10) || (op == 11);
      exp_addr = (op == 8 || op == 10) ? m_reg[s2] : sx(instr[7:0]);
      ins = instr;
      chk("pc_fetch", pc_o, m_pc);
      for (int i = 0; i < ins_stall; i++) begin
         @(posedge CLK); @(negedge CLK);
         chk("pc_ins_stall", pc_o, m_pc);
         chk("strobe_ins_stall", {30'd0, rd_o, wr_o}, 32'd0);
      end
      bw_ins = 1'b0;
      @(posedge CLK); @(negedge CLK);
      bw_ins = 1'b1;
      ins    = $urandom;
      chk("strobe_exec", {30'd0, rd_o, wr_o}, 32'd0);
      @(posedge CLK); @(negedge CLK);
      if (is_ld || is_st) begin
         for (int i = 0; i <= mem_stall; i++) begin
            busywait = (i < mem_stall);
            rdata    = (i < mem_stall) ? 16'($urandom) : rdv[15:0];
            chk("strobe_mem", {30'd0, rd_o, wr_o}, is_ld ? 32'd2 : 32'd1);
            chk("addr_mem", addr_o, 32'(exp_addr));
            if (is_st) chk("wdata_mem", wd_o, 32'(m_reg[s1]));
            @(posedge CLK); @(negedge CLK);
         end
         busywait = 1'b0;
         rdata    = 16'($urandom);
      end
      chk("strobe_wb", {30'd0, rd_o, wr_o}, 32'd0);
      chk("pc_before_wb", pc_o, m_pc);
      @(posedge CLK); @(negedge CLK);
      model_step(instr, rdv);
      chk("pc_after", pc_o, m_pc);
      chk("illegal", {31'd0, ill_o}, {31'd0, m_ill});
   endtask

   task automatic dump();
      for (int i = 0; i < 8; i++) exec(enc(8'h0B, 8'h00, 8'(i), 8'($urandom)), 0, 0, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET    = 1'b0;
      bw_ins   = 1'b1;
      busywait = 1'b0;
      repeat (2) @(negedge CLK);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_strobe", {30'd0, rd_o, wr_o}, 32'd0);
      chk("rst_illegal", {31'd0, ill_o}, 32'd0);
      model_reset();
      RESET = 1'b1;
   endtask

   initial begin
      logic [31:0] ri;
      int          op;
      RESET = 1'b0; ins = '0; bw_ins = 1'b1; busywait = 1'b0; rdata = '0;
      sel16 = 1'b0; W = 8;
      model_reset();
      do_reset();
      dump();

      // loadi/loadi/add wrapping to zero, PC 0,4,8,12
      do_reset();
      exec(enc(8'h00, 8'd1, 8'd0, 8'h05), 0, 0, 0);
      exec(enc(8'h00, 8'd2, 8'd0, 8'hFB), 0, 0, 0);
      exec(enc(8'h02, 8'd3, 8'd1, 8'd2), 0, 0, 0);
      chk("s1_pc12", pc_o, 32'd12);
      exec(enc(8'h0B, 8'd0, 8'd3, 8'h20), 0, 0, 0);

      // store with 3 stall cycles, then load back
      exec(enc(8'h0B, 8'd0, 8'd1, 8'h10), 0, 3, 0);
      exec(enc(8'h09, 8'd4, 8'd0, 8'h10), 0, 1, 32'h05);
      exec(enc(8'h0B, 8'd0, 8'd4, 8'h11), 0, 0, 0);

      // branches
      do_reset();
      exec(enc(8'h00, 8'd1, 8'd0, 8'h05), 0, 0, 0);
      exec(enc(8'h00, 8'd0, 8'd0, 8'h00), 0, 0, 0);
      exec(enc(8'h07, 8'hFE, 8'd1, 8'd1), 0, 0, 0);
      chk("s3_beq_pc4", pc_o, 32'd4);
      exec(enc(8'h00, 8'd2, 8'd0, 8'h00), 0, 0, 0);
      exec(enc(8'h0C, 8'h05, 8'd1, 8'd1), 0, 0, 0);
      chk("s3_bne_pc12", pc_o, 32'd12);
      do_reset();
      exec(enc(8'h06, 8'h02, 8'd0, 8'd0), 0, 0, 0);
      chk("s3_j_pc12", pc_o, 32'd12);

      // instruction fetch stall
      exec(enc(8'h00, 8'd5, 8'd0, 8'h33), 5, 0, 0);
      dump();

      // 16-bit shifts of 0x8001
      sel16 = 1'b1; W = 16;
      do_reset();
      exec(enc(8'h00, 8'd1, 8'd0, 8'h80), 0, 0, 0);
      exec(enc(8'h0D, 8'd1, 8'd1, 8'd8), 0, 0, 0);
      exec(enc(8'h00, 8'd2, 8'd0, 8'h01), 0, 0, 0);
      exec(enc(8'h05, 8'd1, 8'd1, 8'd2), 0, 0, 0);
      exec(enc(8'h0F, 8'd3, 8'd1, 8'd20), 0, 0, 0);
      exec(enc(8'h0E, 8'd4, 8'd1, 8'd16), 0, 0, 0);
      exec(enc(8'h10, 8'd5, 8'd1, 8'd17), 0, 0, 0);
      exec(enc(8'h0D, 8'd6, 8'd1, 8'd1), 0, 0, 0);
      dump();

      // random programs on both widths
      for (int s = 0; s < 2; s++) begin
         sel16 = (s == 1);
         W     = (s == 1) ? 16 : 8;
         do_reset();
         for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 16);
            ri = $urandom;
            ri[31:24] = 8'(op);
            exec(ri, $urandom_range(0, 1), $urandom_range(0, 2), $urandom);
         end
         dump();
      end

      // undefined opcode, then reset in the middle of a load
      sel16 = 1'b0; W = 8;
      do_reset();
      exec(enc(8'h00, 8'd1, 8'd0, 8'h11), 0, 0, 0);
      exec(enc(8'h00, 8'd2, 8'd0, 8'h22), 0, 0, 0);
      exec(enc(8'hFF, 8'd1, 8'd2, 8'd3), 0, 0, 0);
      exec(enc(8'h00, 8'd3, 8'd0, 8'h44), 0, 0, 0);
      dump();
      ins = enc(8'h08, 8'd5, 8'd0, 8'd1);
      bw_ins = 1'b0;
      @(posedge CLK); @(negedge CLK);
      bw_ins = 1'b1;
      busywait = 1'b1;
      @(posedge CLK); @(negedge CLK);
      chk("mid_mem_read", {31'd0, rd_o}, 32'd1);
      RESET = 1'b0;
      #1;
      chk("mid_rst_read", {31'd0, rd_o}, 32'd0);
      chk("mid_rst_write", {31'd0, wr_o}, 32'd0);
      chk("mid_rst_pc", pc_o, 32'd0);
      chk("mid_rst_illegal", {31'd0, ill_o}, 32'd0);
      model_reset();
      busywait = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      dump();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_mc.md
CPU_MC -- requirements
Module: cpu_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 8: register/ALU/data-bus width, legal values 8, 16, 32.
REQ-002 SHALL have parameter REG_COUNT, default 8: number of general registers, a power of two, 2..256.
REQ-003 SHALL have parameter PC_W, default 32: program counter width.
REQ-004 SHALL provide ports: CLK in 1, the single clock, all state on its rising edge; RESET in 1, asynchronous active-low reset.
REQ-005 SHALL provide ports: PC out PC_W, instruction address; INSTRUCTION in 32, fetched word; BUSYWAIT_INS in 1, instruction memory stall.
REQ-006 SHALL provide ports: READ_MEM out 1, WRITE_MEM out 1, ADDRESS out DATA_W, WRITEDATA out DATA_W, READDATA in DATA_W, BUSYWAIT in 1 (data memory stall).
REQ-007 SHALL provide port ILLEGAL out 1, sticky: undefined opcode decoded.

Function
REQ-008 SHALL decode INSTRUCTION as opcode[31:24], dest/offset[23:16], src1[15:8], src2/imm[7:0]; register fields use the low log2(REG_COUNT) bits.
REQ-009 SHALL implement opcodes 0x00 loadi, 0x01 mov, 0x02 add, 0x03 sub, 0x04 and, 0x05 or, 0x06 j, 0x07 beq, 0x08 lwd, 0x09 lwi, 0x0A swd, 0x0B swi, 0x0C bne, 0x0D sll, 0x0E srl, 0x0F sra, 0x10 ror.
REQ-010 SHALL sign-extend the 8-bit immediate to DATA_W; add/sub wrap modulo 2^DATA_W.
REQ-011 SHALL run a four-state FSM: FETCH, EXEC, MEM, WB.
REQ-012 FETCH: SHALL latch INSTRUCTION into the instruction register on the first edge with BUSYWAIT_INS low, then go to EXEC; stay in FETCH otherwise.
REQ-013 EXEC: SHALL read operands, compute the ALU result and branch decision, latch both, then go to MEM for loads/stores and to WB otherwise.
REQ-014 MEM: SHALL hold READ_MEM (loads) or WRITE_MEM (stores) high, with ADDRESS and WRITEDATA stable, until the edge at which BUSYWAIT is sampled low; then drop the strobe and go to WB.
REQ-015 WB: SHALL write the destination register (ALU result, or READDATA latched at the MEM exit edge); stores and branches write nothing.
REQ-016 WB: SHALL set PC to PC+4, or to PC+4+(sign-extended offset<<2) for j, for beq with equal operands, and for bne with unequal operands; then go to FETCH.
REQ-017 Latency SHALL be 3 cycles for non-memory instructions and 4+N for memory instructions, where N is the number of BUSYWAIT-high cycles; FETCH adds one cycle per BUSYWAIT_INS-high cycle.
REQ-018 Shift amount is imm[7:0] unsigned; SHALL produce 0 for sll/srl at amount >= DATA_W; sra at amount >= DATA_W SHALL fill with the sign bit; ror SHALL rotate by amount mod DATA_W.
REQ-019 An undefined opcode SHALL execute as a NOP (PC+4, no write) and set ILLEGAL until reset.
REQ-020 READ_MEM and WRITE_MEM SHALL never be high together and SHALL be low outside MEM.
REQ-021 PC SHALL wrap modulo 2^PC_W.

Reset
REQ-022 RESET low SHALL asynchronously force PC=0, FSM=FETCH, all registers 0, READ_MEM=WRITE_MEM=0, ILLEGAL=0, instruction register 0.
REQ-023 Reset asserted mid-MEM SHALL drop the strobes immediately, perform no register write and no PC update; after release, fetch starts at PC 0.

Structure
REQ-024 Opcode constants, FSM state encodings and the ALU-op encoding SHALL live in shared package cpu_pkg.
REQ-025 The register file SHALL be sub-module reg_file_p (parameters DATA_W, REG_COUNT; two asynchronous read ports, one synchronous write port, async active-low clear); the ALU and FSM stay in cpu_mc.

Verification
REQ-026 Scenario 1: DATA_W=8, loadi r1,0x05; loadi r2,0xFB; add r3,r1,r2 -> r3=0x00; each instruction takes 3 cycles; PC reads 0,4,8,12.
REQ-027 Scenario 2: swi r1,0x10 with BUSYWAIT high for 3 cycles -> WRITE_MEM high 4 cycles, ADDRESS=0x10, WRITEDATA=0x05; then lwi r4,0x10 with READDATA=0x05 -> r4=0x05.
REQ-028 Scenario 3: beq r1,r1,offset 0xFE at PC 8 -> PC becomes 4; bne r1,r1 -> PC becomes 12; j 0x02 at PC 0 -> PC becomes 12.
REQ-029 Scenario 4: DATA_W=16, r1=0x8001: sra by 20 -> 0xFFFF; srl by 16 -> 0x0000; ror by 17 -> 0xC000; sll by 1 -> 0x0002.
REQ-030 Scenario 5: opcode 0xFF -> ILLEGAL=1 and held, PC+4, no register changes; RESET low during the MEM of a lwd -> READ_MEM low immediately, PC=0, all registers 0, ILLEGAL=0.
REQ-031 Scenario 6: BUSYWAIT_INS high for 5 cycles at FETCH -> PC and registers hold, instruction latched on the first low cycle, no memory strobes during the stall.
